// File: rtl/rr_arb_ctrl_if.sv
// rtl/rr_arb_ctrl_if.sv - request/grant bundle between requesters and the round-robin arbiter
interface rr_arb_ctrl_if #(
    parameter int W = 8,
    parameter int D = $clog2(W)
) ();
    logic [W-1:0] req;
    logic         ack;
    logic [W-1:0] gnt;
    logic [D-1:0] gnt_id;
    logic         gnt_vld;
    logic         timeout;

    // requester / downstream side
    modport master (
        output req,
        output ack,
        input  gnt,
        input  gnt_id,
        input  gnt_vld,
        input  timeout
    );

    // arbiter side
    modport slave (
        input  req,
        input  ack,
        output gnt,
        output gnt_id,
        output gnt_vld,
        output timeout
    );
endinterface

// File: rtl/rr_arb_ctrl.sv
// rtl/rr_arb_ctrl.sv - round-robin arbiter with held grants; RR_ARB_TIMEOUT_EN adds a grant watchdog
module rr_arb_ctrl #(
    parameter int W       = 8,
    parameter int D       = $clog2(W),
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    rr_arb_ctrl_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [D-1:0] ptr_q, ptr_d;
    logic [W-1:0] gnt_q, gnt_d;
    logic [D-1:0] id_q, id_d;
    logic         vld_q, vld_d;
    logic         to_q, to_d;

    logic [D-1:0] adv_ptr;
    logic [D-1:0] sel_ptr;
    logic [D-1:0] win;
    logic         win_vld;
    logic         fire;
    logic         release_grant;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;
    logic [CW-1:0] hold_q, hold_d;

    // watchdog trips on the last permitted busy cycle unless the downstream acks in it
    assign fire = (state_q == BUSY) && !bus.ack && (hold_q == CW'(TIMEOUT - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT > 0);
    assign fire = 1'b0;
`endif

    // a grant ends on ack, or on a watchdog trip which behaves exactly like an ack
    assign release_grant = (state_q == BUSY) && (bus.ack || fire);

    // pointer moves one past the current winner, wrapping at W-1 (W need not be a power of two)
    assign adv_ptr = (id_q == D'(W - 1)) ? '0 : id_q + 1'b1;

    // back-to-back re-arbitration must already see the advanced pointer
    assign sel_ptr = release_grant ? adv_ptr : ptr_q;

    // rotating find-first-set: lowest request at/above sel_ptr, else lowest request overall
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                win     = D'(i);
                win_vld = 1'b1;
            end
        end
        for (int i = W - 1; i >= 0; i--) begin
            if (bus.req[i] && (D'(i) >= sel_ptr)) begin
                win = D'(i);
            end
        end
    end

    // next-state and registered-output values for the grant sequencer
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        vld_d   = vld_q;
        to_d    = fire;
`ifdef RR_ARB_TIMEOUT_EN
        hold_d  = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    gnt_d   = {{(W - 1){1'b0}}, 1'b1} << win;
                    id_d    = win;
                    vld_d   = 1'b1;
                    state_d = BUSY;
`ifdef RR_ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            BUSY: begin
                if (release_grant) begin
                    ptr_d = adv_ptr;
                    if (win_vld) begin
                        gnt_d  = {{(W - 1){1'b0}}, 1'b1} << win;
                        id_d   = win;
                        vld_d  = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
                        hold_d = '0;
`endif
                    end else begin
                        gnt_d   = '0;
                        id_d    = '0;
                        vld_d   = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
`ifdef RR_ARB_TIMEOUT_EN
                    hold_d = hold_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state and output registers; reset drops any outstanding grant immediately
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            id_q    <= '0;
            vld_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            vld_q   <= vld_d;
            to_q    <= to_d;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    // hold counter for the watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = id_q;
    assign bus.gnt_vld = vld_q;
    assign bus.timeout = to_q;
endmodule

// File: tb/tb_rr_arb_ctrl.sv
// tb/tb_rr_arb_ctrl.sv - self-checking bench for rr_arb_ctrl
module tb_rr_arb_ctrl;
    localparam int W  = 8;
    localparam int D  = 3;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_arb_ctrl_if #(.W(W), .D(D)) bus ();
    rr_arb_ctrl #(.W(W), .D(D), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef RR_ARB_TIMEOUT_EN
    logic rst4;
    rr_arb_ctrl_if #(.W(W), .D(D)) bus4 ();
    rr_arb_ctrl #(.W(W), .D(D), .TIMEOUT(4)) dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (bus4)
    );
`endif

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // reference model: scan requesters in rotating order starting at the pointer
    int m_ptr, m_id, m_hold;
    bit m_vld, m_to;

    function automatic int pick(input logic [W-1:0] r, input int p);
        for (int k = 0; k < W; k++) begin
            if (r[(p + k) % W]) return (p + k) % W;
        end
        return -1;
    endfunction

    task automatic model_step(input bit r_st, input logic [W-1:0] r, input bit a);
        int  w;
        bit  rel;
        m_to = 1'b0;
        if (r_st) begin
            m_ptr = 0; m_id = 0; m_vld = 1'b0; m_hold = 0;
        end else if (!m_vld) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_id = w; m_vld = 1'b1; m_hold = 0;
            end
        end else begin
            rel = a;
`ifdef RR_ARB_TIMEOUT_EN
            if (!a && m_hold == TO - 1) begin
                rel  = 1'b1;
                m_to = 1'b1;
            end
`endif
            if (rel) begin
                m_ptr = (m_id + 1) % W;
                w = pick(r, m_ptr);
                if (w >= 0) begin
                    m_id = w; m_hold = 0;
                end else begin
                    m_vld = 1'b0; m_id = 0;
                end
            end else begin
                m_hold++;
            end
        end
    endtask

    typedef struct {
        bit         rst;
        logic [7:0] req;
        bit         ack;
        int         id;
        bit         vld;
    } vec_t;

    vec_t tv[$];

    function automatic void add(input bit r, input logic [7:0] q, input bit a, input int id, input bit v);
        vec_t e;
        e.rst = r; e.req = q; e.ack = a; e.id = id; e.vld = v;
        tv.push_back(e);
    endfunction

    initial begin
        logic [W-1:0] exp_gnt;
        logic [W-1:0] r;
        bit           a, rs;
        int           good;

        rst = 1'b1;
        bus.req = '0;
        bus.ack = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
        rst4 = 1'b1;
        bus4.req = '0;
        bus4.ack = 1'b0;
`endif

        // reset, full rotation, sparse wrap, hold stability, idle return, mid-grant reset
        add(1, 8'h00, 0, 0, 0);
        add(0, 8'hFF, 0, 0, 1);
        for (int i = 1; i < 8; i++) add(0, 8'hFF, 1, i, 1);
        add(0, 8'hFF, 1, 0, 1);
        add(0, 8'h81, 1, 7, 1);
        add(0, 8'h81, 1, 0, 1);
        add(0, 8'h81, 1, 7, 1);
        add(0, 8'h81, 1, 0, 1);
        add(0, 8'h04, 1, 2, 1);
        for (int i = 0; i < 5; i++) add(0, 8'h01, 0, 2, 1);
        add(0, 8'h01, 1, 0, 1);
        add(0, 8'h04, 1, 2, 1);
        add(0, 8'h00, 1, 0, 0);
        add(0, 8'h0C, 0, 3, 1);
        add(0, 8'h0C, 1, 2, 1);
        add(0, 8'h00, 0, 2, 1);
        add(0, 8'h00, 1, 0, 0);
        add(0, 8'h00, 1, 0, 0);
        add(0, 8'h08, 1, 3, 1);
        add(1, 8'hFF, 0, 0, 0);
        add(0, 8'hFF, 0, 0, 1);

        foreach (tv[i]) begin
            rst = tv[i].rst;
            bus.req = tv[i].req;
            bus.ack = tv[i].ack;
            cycle();
            exp_gnt = tv[i].vld ? (W'(1) << tv[i].id) : '0;
            check($sformatf("vec%0d_gnt", i), bus.gnt, exp_gnt);
            check($sformatf("vec%0d_gnt_id", i), bus.gnt_id, tv[i].id);
            check($sformatf("vec%0d_gnt_vld", i), bus.gnt_vld, tv[i].vld);
            check($sformatf("vec%0d_timeout", i), bus.timeout, 0);
        end

        // randomized traffic against the reference model
        rst = 1'b1; bus.req = '0; bus.ack = 1'b0;
        model_step(1'b1, '0, 1'b0);
        cycle();
        for (int n = 0; n < 3000; n++) begin
            rs = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 3))
                0: r = '0;
                1: r = W'($urandom);
                2: r = W'(1) << $urandom_range(0, W - 1);
                default: r = W'($urandom & $urandom);
            endcase
            a = ($urandom_range(0, 2) == 0);
            rst = rs; bus.req = r; bus.ack = a;
            model_step(rs, r, a);
            cycle();
            exp_gnt = m_vld ? (W'(1) << m_id) : '0;
            check("rnd_gnt", bus.gnt, exp_gnt);
            check("rnd_gnt_id", bus.gnt_id, m_id);
            check("rnd_gnt_vld", bus.gnt_vld, m_vld);
            check("rnd_timeout", bus.timeout, m_to);
            check("rnd_onehot", ($countones(bus.gnt) <= 1), 1);
        end

`ifndef RR_ARB_TIMEOUT_EN
        // without the watchdog a grant is held for as long as ack stays low
        rst = 1'b1; bus.req = '0; bus.ack = 1'b0;
        cycle();
        rst = 1'b0; bus.req = 8'h03;
        good = 0;
        for (int n = 0; n < 120; n++) begin
            cycle();
            if (bus.gnt_vld && bus.gnt == 8'h01 && bus.gnt_id == 0 && !bus.timeout) good++;
        end
        check("hold_120_cycles", good, 120);
`else
        // watchdog with TIMEOUT=4 revokes grant 0 and moves on to requester 1
        rst4 = 1'b1;
        cycle();
        rst4 = 1'b0; bus4.req = 8'h03; bus4.ack = 1'b0;
        cycle();
        check("to_first_gnt_id", bus4.gnt_id, 0);
        check("to_first_vld", bus4.gnt_vld, 1);
        for (int n = 0; n < 3; n++) begin
            cycle();
            check("to_wait_timeout", bus4.timeout, 0);
            check("to_wait_gnt_id", bus4.gnt_id, 0);
        end
        cycle();
        check("to_pulse", bus4.timeout, 1);
        check("to_next_gnt_id", bus4.gnt_id, 1);
        check("to_next_gnt", bus4.gnt, 8'h02);
        cycle();
        check("to_pulse_end", bus4.timeout, 0);
        check("to_hold_gnt_id", bus4.gnt_id, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rr_arb_ctrl.md
Name: rr_arb_ctrl

Overview:
Round-robin arbiter and grant sequencer that shares one downstream resource among W requesters. It uses a rotating-priority find-first-set search, with the search start set by a registered pointer. Each grant is registered and held stable until the downstream side acknowledges it. The pointer then advances past the winner. The block sits between the requester array and the shared datapath port.

Parameters:
W, 8, number of requesters (W >= 2; need not be a power of two)
D, $clog2(W), width of the grant index
TIMEOUT, 16, max cycles a grant is held without ack (used only when RR_ARB_TIMEOUT_EN is defined; TIMEOUT >= 1)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  synchronous active-high reset
req  input  W  request vector, bit i = requester i
ack  input  1  downstream has completed/accepted the current grant (qualified by gnt_vld)
gnt  output  W  registered one-hot grant, all-zero when idle
gnt_id  output  D  registered binary index of the granted requester
gnt_vld  output  1  registered, high while a grant is outstanding
timeout  output  1  one-cycle pulse when a grant is revoked by the watchdog (tied 0 without RR_ARB_TIMEOUT_EN)

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, ptr=0, gnt=0, gnt_id=0, gnt_vld=0, timeout=0, hold counter=0.
  - Reset takes priority over every other event, including mid-grant; any outstanding grant is dropped with no ack required.
- Winner selection (combinational):
  - masked = req & ~((1<<ptr)-1), i.e. bits at or above ptr.
  - If masked != 0, winner = lowest set index in masked; otherwise winner = lowest set index in req.
  - With req == 0 there is no winner.
- State IDLE (gnt_vld=0):
  - If req != 0, register gnt = 1<<winner, gnt_id = winner, gnt_vld=1, then go to BUSY.
  - Latency is 1 cycle from req sampled to gnt_vld high.
  - If req == 0, stay in IDLE with outputs at zero.
- State BUSY (gnt_vld=1):
  - gnt and gnt_id stay frozen regardless of req changes; the grant is not revoked if the requester drops req.
  - ack is ignored in IDLE.
  - On ack: ptr <= (gnt_id == W-1) ? 0 : gnt_id+1.
  - Back-to-back: in the same cycle as ack, the winner is re-evaluated against the current req using the updated ptr value.
    - If a winner exists, load the new grant; gnt_vld stays 1 with no bubble.
    - Otherwise clear gnt/gnt_id, set gnt_vld=0 and go to IDLE.
  - A requester granted on ack cannot win again while any other requester at or above the new ptr, or below it, is requesting. This gives worst-case wait <= W-1 grants.
- gnt is always one-hot or zero.
- gnt_id is valid only when gnt_vld=1, and holds 0 when idle.

Optional Feature:
RR_ARB_TIMEOUT_EN
- Defined:
  - A hold counter clears on every new grant and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT-1 with no ack, the block pulses timeout=1 for one cycle.
  - On that same edge it treats the event as an ack: the pointer advances past gnt_id, and re-arbitration or the return to IDLE follows.
  - An ack in the timeout cycle counts as a normal ack and timeout stays 0.
- Not defined: no counter is present, timeout is constant 0, and a grant is held indefinitely until ack.

Test Plan:
- Reset: assert rst with req=8'hFF mid-BUSY -> next cycle gnt=0, gnt_id=0, gnt_vld=0. After release, first grant is gnt=8'h01.
- Full rotation: req=8'hFF held, ack high every cycle gnt_vld=1 -> gnt_id sequence 0,1,2,...,7,0 with gnt_vld continuously 1.
- Sparse wrap: req=8'h81, ack every grant -> gnt_id alternates 0,7,0,7, and gnt is 8'h01/8'h80.
- Hold stability: grant gnt_id=2, then change req to 8'h01 for 5 cycles with ack=0 -> gnt stays 8'h04 and gnt_vld=1. Ack -> next gnt_id=0.
- Idle return and pointer: ack grant 2 with req=0 -> next cycle gnt_vld=0. Then req=8'h0C -> gnt_id=3 (ptr=3), 1 cycle later.
- Timeout (RR_ARB_TIMEOUT_EN, TIMEOUT=4): req=8'h03 and grant 0 with ack=0 -> timeout pulses on the 4th BUSY cycle, and the next grant is gnt_id=1. Without the macro, the grant is held >100 cycles and timeout=0.
